// File: rtl/ram_boot_arb.sv
// Boot shadow-copy of the EEPROM image into SRAM, then round-robin SRAM arbitration between r0 and r1.
// Latency: copy takes 2*COPY_LEN cycles; a request sampled in IDLE at T is acked (with rdata) at T+2.
// Backpressure: requesters hold req/addr/we/wdata until their one-cycle ack; requests during copy wait.
//
// Ports:
//   clk, rst           single clock, synchronous active-low reset
//   done               sticky copy-complete flag
//   rom_a/rom_oe_n/rom_d                      EEPROM read side
//   ram_a/ram_ce_n/ram_oe_n/ram_we_n          SRAM control (all strobes active-low, registered)
//   ram_d_o/ram_d_i                           SRAM write / read data
//   rN_req/rN_we/rN_addr/rN_wdata/rN_ack      requester N (0 = fetch, 1 = data)
//   rdata                                     read data, valid in the ack cycle
module ram_boot_arb #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 8,
    parameter int COPY_LEN = 4096
) (
    input  logic              clk,
    input  logic              rst,
    output logic              done,
    output logic [ADDR_W-1:0] rom_a,
    output logic              rom_oe_n,
    input  logic [DATA_W-1:0] rom_d,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [DATA_W-1:0] ram_d_o,
    input  logic [DATA_W-1:0] ram_d_i,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] rdata
);

    typedef enum logic [1:0] {
        COPY_RD = 2'd0,
        COPY_WR = 2'd1,
        IDLE    = 2'd2,
        ACC     = 2'd3
    } state_t;

    // Terminal count is compared in ADDR_W bits so a full-size copy
    // (COPY_LEN = 2^ADDR_W) stops at the last address instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COPY_LEN - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                rr_q, rr_d;       // index of the requester favoured on a tie
    logic                gnt_q, gnt_d;     // index of the requester owning the current ACC
    logic                acc_we_q, acc_we_d;

    // Every output is a register loaded with the value belonging to the
    // state being entered, so the pins always reflect the current state.
    logic [ADDR_W-1:0]   rom_a_q, rom_a_d;
    logic                rom_oe_n_q, rom_oe_n_d;
    logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
    logic                ram_ce_n_q, ram_ce_n_d;
    logic                ram_oe_n_q, ram_oe_n_d;
    logic                ram_we_n_q, ram_we_n_d;
    logic [DATA_W-1:0]   ram_d_o_q, ram_d_o_d;
    logic                r0_ack_q, r0_ack_d;
    logic                r1_ack_q, r1_ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    // Arbitration selection
    logic                win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    always_comb begin
        win       = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;

        // Tie goes to the pointer; a lone requester always wins.
        if (r0_req && r1_req) begin
            win = rr_q;
        end else begin
            win = r1_req;
        end

        if (win) begin
            sel_we    = r1_we;
            sel_addr  = r1_addr;
            sel_wdata = r1_wdata;
        end else begin
            sel_we    = r0_we;
            sel_addr  = r0_addr;
            sel_wdata = r0_wdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        acc_we_d   = acc_we_q;
        rom_a_d    = rom_a_q;
        rom_oe_n_d = 1'b1;
        ram_a_d    = ram_a_q;
        ram_ce_n_d = 1'b1;
        ram_oe_n_d = 1'b1;
        ram_we_n_d = 1'b1;
        ram_d_o_d  = ram_d_o_q;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;
        rdata_d    = rdata_q;

        case (state_q)
            COPY_RD: begin
                // ROM byte lands directly in the write-data register that
                // drives the SRAM during the following COPY_WR.
                state_d    = COPY_WR;
                ram_ce_n_d = 1'b0;
                ram_we_n_d = 1'b0;
                ram_d_o_d  = rom_d;
            end

            COPY_WR: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = COPY_RD;
                    cnt_d      = cnt_q + 1'b1;
                    rom_a_d    = cnt_q + 1'b1;
                    ram_a_d    = cnt_q + 1'b1;
                    rom_oe_n_d = 1'b0;
                end
            end

            IDLE: begin
                if (r0_req || r1_req) begin
                    state_d    = ACC;
                    gnt_d      = win;
                    rr_d       = ~win;
                    acc_we_d   = sel_we;
                    ram_a_d    = sel_addr;
                    ram_ce_n_d = 1'b0;
                    if (sel_we) begin
                        ram_we_n_d = 1'b0;
                        ram_d_o_d  = sel_wdata;
                    end else begin
                        ram_oe_n_d = 1'b0;
                    end
                end
            end

            ACC: begin
                state_d = IDLE;
                if (!acc_we_q) begin
                    rdata_d = ram_d_i;
                end
                if (gnt_q) begin
                    r1_ack_d = 1'b1;
                end else begin
                    r0_ack_d = 1'b1;
                end
            end

            default: begin
                state_d = COPY_RD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= COPY_RD;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            rr_q       <= 1'b0;
            gnt_q      <= 1'b0;
            acc_we_q   <= 1'b0;
            rom_a_q    <= '0;
            rom_oe_n_q <= 1'b0;
            ram_a_q    <= '0;
            ram_ce_n_q <= 1'b1;
            ram_oe_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
            ram_d_o_q  <= '0;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            acc_we_q   <= acc_we_d;
            rom_a_q    <= rom_a_d;
            rom_oe_n_q <= rom_oe_n_d;
            ram_a_q    <= ram_a_d;
            ram_ce_n_q <= ram_ce_n_d;
            ram_oe_n_q <= ram_oe_n_d;
            ram_we_n_q <= ram_we_n_d;
            ram_d_o_q  <= ram_d_o_d;
            r0_ack_q   <= r0_ack_d;
            r1_ack_q   <= r1_ack_d;
            rdata_q    <= rdata_d;
        end
    end

    assign done     = done_q;
    assign rom_a    = rom_a_q;
    assign rom_oe_n = rom_oe_n_q;
    assign ram_a    = ram_a_q;
    assign ram_ce_n = ram_ce_n_q;
    assign ram_oe_n = ram_oe_n_q;
    assign ram_we_n = ram_we_n_q;
    assign ram_d_o  = ram_d_o_q;
    assign r0_ack   = r0_ack_q;
    assign r1_ack   = r1_ack_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_ram_boot_arb.sv
// Bench for ram_boot_arb with COPY_LEN = 16: boot copy, table-driven accesses,
// contention, early request, random traffic against a memory/arbitration model,
// and resets mid-copy and mid-access.
module tb_ram_boot_arb;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int CL = 16;

    logic          clk;
    logic          rst;
    logic          done;
    logic [AW-1:0] rom_a;
    logic          rom_oe_n;
    logic [DW-1:0] rom_d;
    logic [AW-1:0] ram_a;
    logic          ram_ce_n, ram_oe_n, ram_we_n;
    logic [DW-1:0] ram_d_o, ram_d_i;
    logic          r0_req, r0_we, r0_ack;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r1_req, r1_we, r1_ack;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic [DW-1:0] rdata;

    ram_boot_arb #(.ADDR_W(AW), .DATA_W(DW), .COPY_LEN(CL)) dut (
        .clk(clk), .rst(rst), .done(done),
        .rom_a(rom_a), .rom_oe_n(rom_oe_n), .rom_d(rom_d),
        .ram_a(ram_a), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
        .ram_d_o(ram_d_o), .ram_d_i(ram_d_i),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ack(r0_ack),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ack(r1_ack),
        .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memories
    logic [DW-1:0] rom_mem [4096];
    logic [DW-1:0] ram_mem [4096];

    assign rom_d   = rom_oe_n ? 8'hEE : rom_mem[rom_a];
    assign ram_d_i = (!ram_ce_n && !ram_oe_n && ram_we_n) ? ram_mem[ram_a] : 8'hEE;
    always @(posedge clk) if (!ram_ce_n && !ram_we_n) ram_mem[ram_a] <= ram_d_o;

    // Reference model: expected RAM contents, held read data, last grant
    logic [DW-1:0] sbmem [4096];
    bit            vld   [4096];
    logic [DW-1:0] prev_rdata;
    bit            last_win;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4096; i++) vld[i] = 1'b0;
        prev_rdata = 8'h00;
        last_win   = 1'b1;   // r0 wins the first tie
    endtask

    task automatic model_copied();
        for (int i = 0; i < CL; i++) begin
            sbmem[i] = 8'hA0 + 8'(i);
            vld[i]   = 1'b1;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " done"},     done, 0);
        chk({tag, " r0_ack"},   r0_ack, 0);
        chk({tag, " r1_ack"},   r1_ack, 0);
        chk({tag, " rdata"},    rdata, 0);
        chk({tag, " rom_a"},    rom_a, 0);
        chk({tag, " ram_a"},    ram_a, 0);
        chk({tag, " ram_d_o"},  ram_d_o, 0);
        chk({tag, " rom_oe_n"}, rom_oe_n, 0);
        chk({tag, " ram_ce_n"}, ram_ce_n, 1);
        chk({tag, " ram_oe_n"}, ram_oe_n, 1);
        chk({tag, " ram_we_n"}, ram_we_n, 1);
    endtask

    // One-cycle reset, checks reset values, releases; leaves time at #1 after the reset edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        r0_req = 1'b0; r1_req = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals(tag);
        rst = 1'b1;
        model_reset();
    endtask

    // Follows a full copy after reset release; expects done on cycle 2*CL.
    task automatic wait_copy();
        int idx;
        int done_k;
        idx = 0;
        done_k = 0;
        for (int k = 1; k <= 2 * CL + 8; k++) begin
            @(posedge clk); #1;
            if (!ram_we_n) begin
                chk("copy ram_a", ram_a, idx);
                chk("copy ram_d_o", ram_d_o, 32'hA0 + idx);
                chk("copy rom_oe_n during write", rom_oe_n, 1);
                idx++;
            end
            if (k == 2 * CL - 1) chk("done low before end", done, 0);
            if (done) begin
                done_k = k;
                break;
            end
        end
        chk("copy write pulses", idx, CL);
        chk("done cycle", done_k, 2 * CL);
        model_copied();
    endtask

    // Drives one or two simultaneous requests from IDLE; checks ack timing,
    // ram_a/ram_we_n in each ACC cycle, and rdata against the model.
    task automatic access2(input bit u0, input bit u1, input bit w0, input bit w1,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           output logic [DW-1:0] got0, output logic [DW-1:0] got1);
        int            order [2];
        int            n;
        logic [AW-1:0] addr_e [2];
        bit            we_e   [2];
        logic [DW-1:0] exp_rd [2];
        int            j;
        bit            e0, e1;
        if (u0 && u1) begin
            order[0] = last_win ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = u0 ? 0 : 1;
            order[1] = 0;
            n = 1;
        end
        last_win = (order[n-1] == 1);
        for (int i = 0; i < n; i++) begin
            addr_e[i] = (order[i] == 1) ? a1 : a0;
            we_e[i]   = (order[i] == 1) ? w1 : w0;
            if (we_e[i]) begin
                sbmem[addr_e[i]] = (order[i] == 1) ? d1 : d0;
                vld[addr_e[i]]   = 1'b1;
                exp_rd[i] = prev_rdata;
            end else begin
                exp_rd[i]  = sbmem[addr_e[i]];
                prev_rdata = sbmem[addr_e[i]];
            end
        end
        r0_req = u0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_req = u1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        got0 = 8'h00;
        got1 = 8'h00;
        for (int c = 1; c <= 2 * n; c++) begin
            @(posedge clk); #1;
            j  = (c - 1) / 2;
            e0 = (c % 2 == 0) && (order[j] == 0);
            e1 = (c % 2 == 0) && (order[j] == 1);
            if (c % 2 == 1) begin
                chk("acc ram_a", ram_a, addr_e[j]);
                chk("acc ram_we_n", ram_we_n, !we_e[j]);
            end
            chk("r0_ack timing", r0_ack, e0);
            chk("r1_ack timing", r1_ack, e1);
            if (c % 2 == 0) begin
                chk("rdata vs model", rdata, exp_rd[j]);
                if (order[j] == 0) begin
                    got0 = rdata;
                    r0_req = 1'b0;
                end else begin
                    got1 = rdata;
                    r1_req = 1'b0;
                end
            end
        end
    endtask

    typedef struct {
        bit            n;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          tbl [9];
    logic [DW-1:0] g0, g1, gsel;
    int            early;
    bit            ru0, ru1, rw0, rw1;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    int            mode, gap;

    initial begin
        rst = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            rom_mem[i] = (i < CL) ? 8'hA0 + 8'(i) : 8'($urandom);
            ram_mem[i] = 8'h00;
        end

        // Records: requester, write, address, write data, rdata in the ack cycle
        tbl[0] = '{1'b1, 1'b1, 12'h00A, 8'h3C, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 12'h00A, 8'h00, 8'h3C};
        tbl[2] = '{1'b0, 1'b0, 12'h005, 8'h00, 8'hA5};
        tbl[3] = '{1'b0, 1'b1, 12'h000, 8'h55, 8'hA5};
        tbl[4] = '{1'b1, 1'b0, 12'h000, 8'h00, 8'h55};
        tbl[5] = '{1'b0, 1'b0, 12'h00F, 8'h00, 8'hAF};
        tbl[6] = '{1'b1, 1'b1, 12'hFFF, 8'hFF, 8'hAF};
        tbl[7] = '{1'b0, 1'b0, 12'hFFF, 8'h00, 8'hFF};
        tbl[8] = '{1'b0, 1'b0, 12'h00A, 8'h00, 8'h3C};

        // Boot copy
        do_reset("reset");
        wait_copy();

        // Table-driven single accesses
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].n)
                access2(1'b0, 1'b1, 1'b0, tbl[i].we, '0, tbl[i].addr, '0, tbl[i].wdata, g0, g1);
            else
                access2(1'b1, 1'b0, tbl[i].we, 1'b0, tbl[i].addr, '0, tbl[i].wdata, '0, g0, g1);
            gsel = tbl[i].n ? g1 : g0;
            chk($sformatf("tbl[%0d] rdata", i), gsel, tbl[i].exp_rdata);
        end

        // Contention: both hold req from the first IDLE after reset
        do_reset("reset2");
        wait_copy();
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h001;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h002;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            chk("contend r0_ack", r0_ack, (c == 2 || c == 6));
            chk("contend r1_ack", r1_ack, (c == 4 || c == 8));
            if (c % 2 == 0) chk("contend rdata", rdata, (c % 4 == 2) ? 8'hA1 : 8'hA2);
        end
        r0_req = 1'b0; r1_req = 1'b0;

        // Early request during copy
        do_reset("reset3");
        early = 0;
        for (int k = 1; k <= 2 * CL + 2; k++) begin
            @(posedge clk); #1;
            if (k < 2 * CL + 2 && (r0_ack || r1_ack)) early++;
            if (k == 2) begin
                r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h003;
            end
        end
        chk("early no premature ack", early, 0);
        chk("early r0_ack", r0_ack, 1);
        chk("early r1_ack", r1_ack, 0);
        chk("early rdata", rdata, 8'hA3);
        r0_req = 1'b0;
        model_copied();
        prev_rdata = 8'hA3;
        last_win   = 1'b0;

        // Random traffic
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            ru0 = (mode != 1);
            ru1 = (mode != 0);
            ra0 = 12'($urandom_range(0, 31));
            ra1 = 12'($urandom_range(0, 31));
            rw0 = $urandom_range(0, 1) == 1 || !vld[ra0];
            rw1 = $urandom_range(0, 1) == 1 || !vld[ra1];
            rd0 = 8'($urandom);
            rd1 = 8'($urandom);
            access2(ru0, ru1, rw0, rw1, ra0, ra1, rd0, rd1, g0, g1);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
                chk("idle no r0_ack", r0_ack, 0);
                chk("idle no r1_ack", r1_ack, 0);
            end
        end

        // Reset during an r1 write access
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'h005; r1_wdata = 8'h77;
        @(posedge clk); #1;
        chk("midacc in ACC we_n", ram_we_n, 0);
        rst = 1'b0;
        r1_req = 1'b0;
        @(posedge clk); #1;
        chk("midacc r1_ack", r1_ack, 0);
        chk("midacc ram_we_n", ram_we_n, 1);
        chk("midacc done", done, 0);
        chk("midacc rom_a", rom_a, 0);
        chk("midacc rom_oe_n", rom_oe_n, 0);
        rst = 1'b1;
        model_reset();
        wait_copy();
        access2(1'b1, 1'b0, 1'b0, 1'b0, 12'h005, '0, '0, '0, g0, g1);
        chk("after midacc read", g0, 8'hA5);

        // Reset mid-copy at address 7
        do_reset("reset4");
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("midcopy rom_a at 7", rom_a, 7);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("midcopy");
        rst = 1'b1;
        model_reset();
        wait_copy();
        access2(1'b0, 1'b1, 1'b0, 1'b0, '0, 12'h007, '0, '0, g0, g1);
        chk("after midcopy read", g1, 8'hA7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
